// File: rtl/fb_line_fetch_if.sv
// Frame-buffer bus bundle: the single on-chip memory port plus the
// render-core write-request handshake. The fetch block uses the slave
// modport; the memory and render core sit on the master side.
interface fb_line_fetch_if;
  logic [15:0] OCM_ADDR;
  logic [15:0] OCM_DATAIN;
  logic        OCM_WE;
  logic [15:0] OCM_DATAOUT;
  logic        WR_REQ;
  logic [14:0] WR_ADDR;
  logic [11:0] WR_DATA;
  logic        WR_ACK;

  modport slave (
    output OCM_ADDR, OCM_DATAIN, OCM_WE, WR_ACK,
    input  OCM_DATAOUT, WR_REQ, WR_ADDR, WR_DATA
  );

  modport master (
    input  OCM_ADDR, OCM_DATAIN, OCM_WE, WR_ACK,
    output OCM_DATAOUT, WR_REQ, WR_ADDR, WR_DATA
  );
endinterface

// File: rtl/fb_line_fetch.sv
// Frame-buffer line fetcher: during horizontal blank it copies the next
// frame-buffer row into a local line buffer, otherwise it services
// single-word render-core writes. The line buffer is scanned out with
// 4x horizontal pixel replication into registered VGA colour outputs.
module fb_line_fetch #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_TOTAL     = 525
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [9:0]           DRAW_X,
  input  logic [9:0]           DRAW_Y,
  input  logic                 BLANK,
  fb_line_fetch_if.slave       bus,
  output logic [3:0]           VGA_R,
  output logic [3:0]           VGA_G,
  output logic [3:0]           VGA_B,
  output logic                 FILL_BUSY,
  output logic                 FILL_ERR
);

  localparam int unsigned KW = $clog2(FB_W);
  localparam int unsigned RW = $clog2(FB_H);
  localparam logic [10:0] SCALE_MASK = 11'((1 << SCALE_SHIFT) - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, WRITE} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [RW-1:0]  row_q, row_d;
  logic           err_q, err_d;
  logic [9:0]     x_prev_q;
  logic [11:0]    rgb_q;

  logic [11:0]    line_buf [FB_W];
  logic           lb_we;
  logic [KW-1:0]  lb_waddr;

  logic [10:0]    y_inc;
  logic           trig_edge;
  logic           trig_valid;
  logic [RW-1:0]  trig_row;
  logic [15:0]    fill_addr;
  logic [KW-1:0]  px_idx;
  logic           unused_dout_hi;

  assign unused_dout_hi = ^bus.OCM_DATAOUT[15:12];

  // Trigger qualification: rising into DRAW_X==H_VISIBLE, on the last
  // display line of an FB row, or on the final line of the frame (row 0).
  always_comb begin
    y_inc      = {1'b0, DRAW_Y} + 11'd1;
    trig_edge  = (DRAW_X == 10'(H_VISIBLE)) && (x_prev_q != 10'(H_VISIBLE));
    trig_valid = 1'b0;
    trig_row   = '0;
    if (trig_edge) begin
      if (DRAW_Y == 10'(V_TOTAL - 1)) begin
        trig_valid = 1'b1;
        trig_row   = '0;
      end else if (((y_inc & SCALE_MASK) == '0) && (DRAW_Y < 10'(V_VISIBLE - 1))) begin
        trig_valid = 1'b1;
        trig_row   = RW'(y_inc >> SCALE_SHIFT);
      end
    end
  end

  assign fill_addr = 16'(16'(row_q) * 16'(FB_W)) + 16'(k_q);

  // State, fill counter, target row, error flag and DRAW_X history.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      k_q      <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
      x_prev_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      row_q    <= row_d;
      err_q    <= err_d;
      x_prev_q <= DRAW_X;
    end
  end

  // Next-state and OCM/handshake outputs. Read data trails its address by
  // one CLK, so FILL stores word k-1 and DRAIN stores the last word. DRAIN
  // goes straight to WRITE when a request has been waiting out the fill.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    row_d          = row_q;
    err_d          = err_q;
    bus.OCM_ADDR   = '0;
    bus.OCM_DATAIN = '0;
    bus.OCM_WE     = 1'b0;
    bus.WR_ACK     = 1'b0;
    FILL_BUSY      = 1'b0;
    lb_we          = 1'b0;
    lb_waddr       = k_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (trig_valid) begin
          state_d = FILL;
          k_d     = '0;
          row_d   = trig_row;
        end else if (bus.WR_REQ) begin
          state_d = WRITE;
        end
      end
      FILL: begin
        FILL_BUSY    = 1'b1;
        bus.OCM_ADDR = fill_addr;
        lb_we        = (k_q != '0);
        if (trig_valid) err_d = 1'b1;
        k_d = k_q + 1'b1;
        if (k_q == KW'(FB_W - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        FILL_BUSY = 1'b1;
        lb_we     = 1'b1;
        lb_waddr  = KW'(FB_W - 1);
        k_d       = '0;
        if (trig_valid) err_d = 1'b1;
        state_d = bus.WR_REQ ? WRITE : IDLE;
      end
      WRITE: begin
        bus.WR_ACK = 1'b1;
        if (bus.WR_ADDR < 15'(FB_W * FB_H)) begin
          bus.OCM_ADDR   = {1'b0, bus.WR_ADDR};
          bus.OCM_DATAIN = {4'b0, bus.WR_DATA};
          bus.OCM_WE     = 1'b1;
        end
        if (trig_valid) begin
          state_d = FILL;
          k_d     = '0;
          row_d   = trig_row;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line buffer storage; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (lb_we) line_buf[lb_waddr] <= bus.OCM_DATAOUT[11:0];
  end

  assign px_idx = KW'(DRAW_X >> SCALE_SHIFT);

  // Registered colour: replicated FB pixel in the visible area, black elsewhere.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q <= '0;
    end else if (BLANK && (DRAW_X < 10'(H_VISIBLE))) begin
      rgb_q <= line_buf[px_idx];
    end else begin
      rgb_q <= '0;
    end
  end

  assign VGA_R    = rgb_q[11:8];
  assign VGA_G    = rgb_q[7:4];
  assign VGA_B    = rgb_q[3:0];
  assign FILL_ERR = err_q;

endmodule

// File: tb/tb_fb_line_fetch.sv
// Scoreboard bench for fb_line_fetch: stimulus pushes expected fills,
// writes and pixels into queues; a negedge monitor pops and compares.
module tb_fb_line_fetch;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [9:0] DRAW_X, DRAW_Y;
  logic       BLANK;
  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic       FILL_BUSY, FILL_ERR;

  fb_line_fetch_if bus();

  fb_line_fetch #(
    .FB_W(160), .FB_H(120), .SCALE_SHIFT(2),
    .H_VISIBLE(640), .V_VISIBLE(480), .V_TOTAL(525)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y),
    .BLANK(BLANK), .bus(bus), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .FILL_BUSY(FILL_BUSY), .FILL_ERR(FILL_ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int unsigned i);
    if (i == 19045) return 16'h0ABC;
    return 16'hF000 | 16'((i * 37 + 5) & 32'hFFF);
  endfunction

  // OCM model: synchronous read, one CLK latency
  logic [15:0] mem [0:65535];
  logic [15:0] rdata;
  logic        init_mem = 1'b0;
  logic [11:0] shadow [0:19199];

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 19200; i++) mem[i] <= pat(i);
    end else if (bus.OCM_WE) begin
      mem[bus.OCM_ADDR] <= bus.OCM_DATAIN;
    end
    rdata <= mem[bus.OCM_ADDR];
  end
  assign bus.OCM_DATAOUT = rdata;

  typedef struct { int unsigned base; bit after_ack; } fill_t;
  typedef struct { bit we; logic [15:0] addr; logic [15:0] data; bit after_fill; } wr_t;
  fill_t       exp_fill[$];
  wr_t         exp_wr[$];
  logic [11:0] exp_pix[$];

  logic pix_valid = 1'b0;
  logic pv_d = 1'b0;
  always @(posedge CLK) pv_d <= pix_valid;

  // Monitor
  bit          run = 0;
  int          cnt = 0;
  bit          prev_busy = 0, prev_ack = 0;
  fill_t       cur;
  wr_t         ew;
  logic [11:0] ep;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      run = 0; cnt = 0; prev_busy = 0; prev_ack = 0;
    end else begin
      if (FILL_BUSY) begin
        if (!run) begin
          run = 1; cnt = 0;
          chk("fill_expected", 32'(exp_fill.size() != 0), 1);
          if (exp_fill.size() != 0) begin
            cur = exp_fill.pop_front();
            if (cur.after_ack) chk("fill_after_write", 32'(prev_ack), 1);
          end
        end
        if (cnt < 160) chk("fill_rd", {15'b0, bus.OCM_WE, bus.OCM_ADDR}, 32'(cur.base + cnt));
        chk("ack_in_fill", 32'(bus.WR_ACK), 0);
        cnt++;
      end else if (run) begin
        run = 0;
        chk("fill_len", 32'(cnt), 161);
      end
      if (bus.WR_ACK) begin
        chk("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          ew = exp_wr.pop_front();
          chk("wr_we", 32'(bus.OCM_WE), 32'(ew.we));
          if (ew.we) begin
            chk("wr_addr", 32'(bus.OCM_ADDR), 32'(ew.addr));
            chk("wr_data", 32'(bus.OCM_DATAIN), 32'(ew.data));
          end
          if (ew.after_fill) chk("wr_after_drain", 32'(prev_busy), 1);
        end
      end
      if (pv_d) begin
        chk("pix_expected", 32'(exp_pix.size() != 0), 1);
        if (exp_pix.size() != 0) begin
          ep = exp_pix.pop_front();
          chk("pix_rgb", {20'b0, VGA_R, VGA_G, VGA_B}, 32'(ep));
        end
      end
      prev_busy = FILL_BUSY;
      prev_ack  = bus.WR_ACK;
    end
  end

  task automatic trigger(input int y);
    @(posedge CLK); #1; DRAW_Y = 10'(y); DRAW_X = 10'd639;
    @(posedge CLK); #1; DRAW_X = 10'd640;
  endtask

  task automatic wait_fill_done();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = FILL_BUSY;
    end
    chk("fill_start_timeout", 32'(seen), 1);
    for (int i = 0; i < 300 && FILL_BUSY; i++) @(negedge CLK);
    chk("fill_end_timeout", 32'(FILL_BUSY), 0);
  endtask

  task automatic pix(input int x0, input int n, input bit blank, input int base);
    for (int x = x0; x < x0 + n; x++) begin
      @(posedge CLK); #1;
      DRAW_X = 10'(x); BLANK = blank; pix_valid = 1'b1;
      exp_pix.push_back((blank && x < 640) ? shadow[base + (x >> 2)] : 12'h000);
    end
    @(posedge CLK); #1; pix_valid = 1'b0; DRAW_X = 10'd700;
  endtask

  task automatic wait_ack();
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLK);
      seen = bus.WR_ACK;
    end
    chk("ack_timeout", 32'(seen), 1);
  endtask

  task automatic do_write(input logic [14:0] a, input logic [11:0] d);
    wr_t w;
    w.we = (a < 15'd19200); w.addr = {1'b0, a}; w.data = {4'b0, d}; w.after_fill = 0;
    exp_wr.push_back(w);
    @(posedge CLK); #1; bus.WR_REQ = 1'b1; bus.WR_ADDR = a; bus.WR_DATA = d;
    wait_ack();
    @(posedge CLK); #1; bus.WR_REQ = 1'b0;
    @(negedge CLK); chk("ack_single", 32'(bus.WR_ACK), 0);
    if (a < 15'd19200) shadow[a] = d;
  endtask

  initial begin
    wr_t w;
    for (int i = 0; i < 19200; i++) begin
      logic [15:0] p;
      p = pat(i);
      shadow[i] = p[11:0];
    end
    RESET_N = 1'b0; DRAW_X = 10'd700; DRAW_Y = 10'd0; BLANK = 1'b0;
    bus.WR_REQ = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
    init_mem = 1'b1;
    repeat (2) @(posedge CLK);
    #1; init_mem = 1'b0;
    chk("rst_addr", 32'(bus.OCM_ADDR), 0);
    chk("rst_we", 32'(bus.OCM_WE), 0);
    chk("rst_ack", 32'(bus.WR_ACK), 0);
    chk("rst_busy", 32'(FILL_BUSY), 0);
    chk("rst_err", 32'(FILL_ERR), 0);
    chk("rst_rgb", {20'b0, VGA_R, VGA_G, VGA_B}, 0);
    @(posedge CLK); #1; RESET_N = 1'b1;

    // Row 119 fill and scan-out on line 476
    exp_fill.push_back('{19040, 0});
    trigger(475);
    wait_fill_done();
    DRAW_Y = 10'd476;
    pix(16, 12, 1'b1, 19040);
    pix(650, 2, 1'b1, 19040);

    // Simple write, then out-of-range write
    do_write(15'd100, 12'h123);
    chk("mem_100", 32'(mem[100]), 32'h0123);
    do_write(15'd19200, 12'hFFF);

    // Write request held across a fill completes right after DRAIN
    @(posedge CLK); #1; DRAW_Y = 10'd3; DRAW_X = 10'd639;
    @(posedge CLK); #1; DRAW_X = 10'd640;
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 15'd200; bus.WR_DATA = 12'h456;
    exp_fill.push_back('{160, 0});
    w.we = 1; w.addr = 16'd200; w.data = 16'h0456; w.after_fill = 1;
    exp_wr.push_back(w);
    wait_ack();
    @(posedge CLK); #1; bus.WR_REQ = 1'b0; DRAW_X = 10'd700;
    shadow[200] = 12'h456;
    @(negedge CLK); chk("mem_200", 32'(mem[200]), 32'h0456);

    // Trigger arriving during WRITE starts FILL on the next CLK
    @(posedge CLK); #1; DRAW_Y = 10'd7; DRAW_X = 10'd639;
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 15'd300; bus.WR_DATA = 12'h789;
    w.we = 1; w.addr = 16'd300; w.data = 16'h0789; w.after_fill = 0;
    exp_wr.push_back(w);
    exp_fill.push_back('{320, 1});
    @(posedge CLK); #1; DRAW_X = 10'd640;
    @(negedge CLK);
    @(posedge CLK); #1; bus.WR_REQ = 1'b0;
    wait_fill_done();
    DRAW_X = 10'd700;
    shadow[300] = 12'h789;

    // Ignored triggers: line not ending an FB row, and last visible line
    trigger(10);
    repeat (4) begin @(negedge CLK); chk("no_fill_y10", 32'(FILL_BUSY), 0); end
    trigger(479);
    repeat (4) begin @(negedge CLK); chk("no_fill_y479", 32'(FILL_BUSY), 0); end
    chk("err_clear", 32'(FILL_ERR), 0);

    // End-of-frame trigger fetches row 0; second trigger mid-fill is an error
    exp_fill.push_back('{0, 0});
    trigger(524);
    @(negedge CLK);
    repeat (10) @(posedge CLK);
    #1; DRAW_X = 10'd639;
    @(posedge CLK); #1; DRAW_X = 10'd640;
    wait_fill_done();
    chk("fill_err_set", 32'(FILL_ERR), 1);
    DRAW_Y = 10'd0;
    pix(0, 8, 1'b1, 0);
    pix(0, 8, 1'b0, 0);

    // Reset at k=80 abandons the fill; the next trigger refills fully
    exp_fill.push_back('{19040, 0});
    trigger(475);
    for (int i = 0; i < 50 && !FILL_BUSY; i++) @(negedge CLK);
    repeat (80) @(posedge CLK);
    #2; RESET_N = 1'b0; DRAW_X = 10'd700;
    #1;
    chk("mrst_busy", 32'(FILL_BUSY), 0);
    chk("mrst_err", 32'(FILL_ERR), 0);
    chk("mrst_addr", 32'(bus.OCM_ADDR), 0);
    chk("mrst_we", 32'(bus.OCM_WE), 0);
    chk("mrst_rgb", {20'b0, VGA_R, VGA_G, VGA_B}, 0);
    @(posedge CLK); #1; RESET_N = 1'b1;
    repeat (3) begin @(negedge CLK); chk("mrst_idle", 32'(FILL_BUSY), 0); end
    exp_fill.push_back('{19040, 0});
    trigger(475);
    wait_fill_done();
    DRAW_Y = 10'd476;
    pix(20, 4, 1'b1, 19040);

    repeat (4) @(posedge CLK);
    chk("fill_q_empty", 32'(exp_fill.size()), 0);
    chk("wr_q_empty", 32'(exp_wr.size()), 0);
    chk("pix_q_empty", 32'(exp_pix.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_line_fetch.md
FB_LINE_FETCH -- requirements
Module: fb_line_fetch

Interface
REQ-001 SHALL have parameters: FB_W, 160, frame-buffer pixels per row; FB_H, 120, frame-buffer rows; SCALE_SHIFT, 2, display-to-FB scale as log2 (4x); H_VISIBLE, 640, visible pixels per line; V_VISIBLE, 480, visible lines; V_TOTAL, 525, lines per frame.
REQ-002 SHALL have ports (name direction width meaning):
- CLK  in  1  main clock, 50 MHz; one pixel spans 2 CLK.
- RESET_N  in  1  asynchronous, active-low reset.
- DRAW_X  in  10  current display column from VGA controller.
- DRAW_Y  in  10  current display line from VGA controller.
- BLANK  in  1  active-low blanking indicator.
- OCM_ADDR  out  16  on-chip frame-buffer address.
- OCM_DATAIN  out  16  write data to OCM.
- OCM_WE  out  1  OCM write enable.
- OCM_DATAOUT  in  16  OCM read data, valid 1 CLK after address.
- WR_REQ  in  1  render-core write request.
- WR_ADDR  in  15  render-core pixel address.
- WR_DATA  in  12  render-core pixel {R[11:8],G[7:4],B[3:0]}.
- WR_ACK  out  1  one-cycle write-accept pulse.
- VGA_R, VGA_G, VGA_B  out  4 each  registered colour.
- FILL_BUSY  out  1  high while line fill is in progress.
- FILL_ERR  out  1  sticky: fill trigger arrived while filling.

Function
REQ-003 SHALL own the single OCM port; FB pixel (x,y) stored at word y*FB_W+x, bits [11:0] RGB, bits [15:12] written 0.
REQ-004 SHALL hold a 160 x 12-bit line buffer holding one FB row.
REQ-005 SHALL detect the fill trigger on the first CLK with DRAW_X==H_VISIBLE after a CLK where DRAW_X!=H_VISIBLE.
REQ-006 SHALL set the target row r=(DRAW_Y+1)>>2 when (DRAW_Y+1)%4==0 and DRAW_Y<V_VISIBLE-1; r=0 when DRAW_Y==V_TOTAL-1; otherwise the trigger is ignored.
REQ-007 SHALL implement FSM states IDLE, FILL, DRAIN, WRITE.
REQ-008 IDLE: a valid trigger -> FILL (k=0); else WR_REQ -> WRITE; fill has priority over writes on the same cycle.
REQ-009 FILL: drive OCM_ADDR=r*FB_W+k, OCM_WE=0, k increments each CLK; data returned each CLK stored at line-buffer index k-1; after k=FB_W-1 is issued -> DRAIN.
REQ-010 DRAIN: store the final word at index FB_W-1, then -> IDLE; a fill thus takes FB_W+1=161 CLK, within the 320-CLK horizontal blank.
REQ-011 FILL_BUSY SHALL be high in FILL and DRAIN only.
REQ-012 WRITE: a single CLK; if WR_ADDR<FB_W*FB_H drive OCM_ADDR=WR_ADDR, OCM_DATAIN={4'b0,WR_DATA}, OCM_WE=1; pulse WR_ACK for this CLK regardless; -> IDLE.
REQ-013 Requester SHALL hold WR_REQ/WR_ADDR/WR_DATA stable until WR_ACK; WR_ACK SHALL stay low during FILL/DRAIN.
REQ-014 A valid trigger arriving in WRITE SHALL be latched and SHALL start FILL on the next CLK.
REQ-015 A valid trigger arriving in FILL or DRAIN SHALL be dropped and set FILL_ERR until reset.
REQ-016 OCM_WE SHALL be high only in WRITE with an in-range address.
REQ-017 Colour output SHALL register, each CLK, line_buffer[DRAW_X>>SCALE_SHIFT] when BLANK==1 and DRAW_X<H_VISIBLE, else 0; latency 1 CLK.

Reset
REQ-018 RESET_N low SHALL asynchronously force state IDLE, k=0, pending trigger clear, and all outputs (OCM_ADDR, OCM_DATAIN, OCM_WE, WR_ACK, VGA_R/G/B, FILL_BUSY, FILL_ERR) to 0.
REQ-019 Line-buffer contents SHALL NOT be reset; reset mid-fill abandons the fill, and the next trigger refills.
REQ-020 Deassertion SHALL take effect on the next CLK edge; no OCM write SHALL occur during the reset cycle.

Verification
REQ-021 Preload OCM word 19200-160+5=19045 with 0x0ABC; DRAW_Y=475, DRAW_X 639->640 -> 161 consecutive reads of 19040..19199, FILL_BUSY high 161 CLK, then on line 476 with DRAW_X=20..23 -> RGB=A,B,C.
REQ-022 WR_REQ with WR_ADDR=100, WR_DATA=0x123 in IDLE -> next CLK OCM_WE=1, OCM_ADDR=100, OCM_DATAIN=0x0123, WR_ACK=1 for one CLK.
REQ-023 WR_REQ held across a fill -> WR_ACK low throughout fill, WRITE occurs on the CLK after DRAIN.
REQ-024 WR_ADDR=19200 -> WR_ACK pulses, OCM_WE stays 0.
REQ-025 DRAW_Y=524 trigger -> reads addresses 0..159; BLANK=0 -> RGB=0 regardless of buffer; forced second trigger mid-fill -> FILL_ERR=1.
REQ-026 RESET_N pulled low at k=80 -> outputs 0 immediately, FSM IDLE; next trigger performs a complete 161-CLK fill.
